// File: rtl/memory_sdpram.sv
// ---------------------------------------------------------------------------
// memory_sdpram
//
// Simple dual-port RAM on a single clock. Port A writes with per-byte
// enables. Port B reads through a configurable output pipeline of
// READ_LATENCY_B stages. This is a behavioural, vendor-independent
// stand-in for a common-clock, no-ECC xpm_memory_sdpram.
//
// Ports:
//   clka    - sole clock for both ports
//   rstb    - synchronous active-high reset of the final read register only
//   ena     - port A enable (gates every lane of wea)
//   wea     - per-lane write enables, one bit per BYTE_WRITE_WIDTH_A lane
//   addra   - write address
//   dina    - write data
//   enb     - port B read enable (gates the first read stage)
//   regceb  - clock enable of the final stage; ignored when latency is 1
//   addrb   - read address
//   doutb   - read data (output of the final stage)
//   sleep   - freezes every register and blocks reads and writes this cycle
// ---------------------------------------------------------------------------
module memory_sdpram #(
  parameter int MEMORY_SIZE        = 256,
  parameter int WRITE_DATA_WIDTH_A = 32,
  parameter int READ_DATA_WIDTH_B  = 32,
  parameter int BYTE_WRITE_WIDTH_A = 8,
  parameter int ADDR_WIDTH_A       = 3,
  parameter int ADDR_WIDTH_B       = 3,
  parameter int READ_LATENCY_B     = 1,
  parameter logic [READ_DATA_WIDTH_B-1:0] READ_RESET_VALUE_B = '0
) (
  input  logic                                             clka,
  input  logic                                             rstb,
  input  logic                                             ena,
  input  logic [WRITE_DATA_WIDTH_A/BYTE_WRITE_WIDTH_A-1:0] wea,
  input  logic [ADDR_WIDTH_A-1:0]                          addra,
  input  logic [WRITE_DATA_WIDTH_A-1:0]                    dina,
  input  logic                                             enb,
  input  logic                                             regceb,
  input  logic [ADDR_WIDTH_B-1:0]                          addrb,
  output logic [READ_DATA_WIDTH_B-1:0]                     doutb,
  input  logic                                             sleep
);

  localparam int DEPTH = MEMORY_SIZE / WRITE_DATA_WIDTH_A;
  localparam int NB    = WRITE_DATA_WIDTH_A / BYTE_WRITE_WIDTH_A;
  localparam int BW    = BYTE_WRITE_WIDTH_A;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Depth expressed at each port's address width (plus one bit) so the
  // range check compares like-sized unsigned quantities.
  localparam logic [ADDR_WIDTH_A:0] DEPTH_A = (ADDR_WIDTH_A + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH_B:0] DEPTH_B = (ADDR_WIDTH_B + 1)'(DEPTH);

  // Storage array starts at all zeros and is never reset.
  logic [WRITE_DATA_WIDTH_A-1:0] mem [DEPTH] = '{default: '0};

  logic                         wr_in_range;
  logic                         rd_in_range;
  logic [IDX_W-1:0]             wr_idx;
  logic [IDX_W-1:0]             rd_idx;
  logic [READ_DATA_WIDTH_B-1:0] rd_word;
  logic [READ_DATA_WIDTH_B-1:0] dout_q;

  // Addresses beyond DEPTH (only reachable when DEPTH is not a power of two
  // or the address is wider than needed) are dropped on write and read as 0.
  assign wr_in_range = ({1'b0, addra} < DEPTH_A);
  assign rd_in_range = ({1'b0, addrb} < DEPTH_B);
  assign wr_idx      = addra[IDX_W-1:0];
  assign rd_idx      = addrb[IDX_W-1:0];

  // rd_word sees the array before this edge's write lands, which gives
  // read-first behaviour on a same-address collision.
  assign rd_word = rd_in_range ? mem[rd_idx] : '0;

  // Port A: lane-masked write, gated by ena and sleep.
  always_ff @(posedge clka) begin
    if (ena && !sleep && wr_in_range) begin
      for (int j = 0; j < NB; j++) begin
        if (wea[j]) begin
          mem[wr_idx][j*BW +: BW] <= dina[j*BW +: BW];
        end
      end
    end
  end

  generate
    if (READ_LATENCY_B == 1) begin : g_lat1
      // Single stage: the capture register is also the output register,
      // so it carries the reset and regceb plays no part.
      logic unused_regceb;
      assign unused_regceb = regceb;

      always_ff @(posedge clka) begin
        if (rstb) begin
          dout_q <= READ_RESET_VALUE_B;
        end else if (enb && !sleep) begin
          dout_q <= rd_word;
        end
      end
    end else begin : g_latn
      // stage[0] is the capture stage; stage[N-2] feeds the output register.
      logic [READ_DATA_WIDTH_B-1:0] stage [READ_LATENCY_B-1];

      // Capture and intermediate stages are never reset, so reads already
      // in flight keep moving while rstb holds the output.
      always_ff @(posedge clka) begin
        if (enb && !sleep) begin
          stage[0] <= rd_word;
        end
        if (!sleep) begin
          for (int i = 1; i < READ_LATENCY_B - 1; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      // Output register: rstb takes priority over regceb and sleep.
      always_ff @(posedge clka) begin
        if (rstb) begin
          dout_q <= READ_RESET_VALUE_B;
        end else if (regceb && !sleep) begin
          dout_q <= stage[READ_LATENCY_B-2];
        end
      end
    end
  endgenerate

  assign doutb = dout_q;

endmodule

// File: tb/tb_memory_sdpram.sv
// ---------------------------------------------------------------------------
// tb_memory_sdpram
//
// Drives two instances of memory_sdpram from the same inputs: a 2-word,
// latency-1 RAM and a 3-word (non power of two), latency-3 RAM. A
// behavioural model tracks each instance: array contents, the value last
// captured by a read, and a history of captures taken on non-sleep edges.
// The model predicts doutb, which is compared after every clock edge.
// ---------------------------------------------------------------------------
module tb_memory_sdpram;

  logic        clka = 1'b0;
  logic        rstb;
  logic        ena;
  logic [3:0]  wea;
  logic [1:0]  addra;
  logic [31:0] dina;
  logic        enb;
  logic        regceb;
  logic [1:0]  addrb;
  logic        sleep;
  logic [31:0] doutb_l1;
  logic [31:0] doutb_l3;

  int total = 0;
  int bad   = 0;

  always #5 clka = ~clka;

  memory_sdpram #(
    .MEMORY_SIZE(64), .WRITE_DATA_WIDTH_A(32), .READ_DATA_WIDTH_B(32),
    .BYTE_WRITE_WIDTH_A(8), .ADDR_WIDTH_A(1), .ADDR_WIDTH_B(1),
    .READ_LATENCY_B(1), .READ_RESET_VALUE_B(32'h0)
  ) u_lat1 (
    .clka(clka), .rstb(rstb), .ena(ena), .wea(wea), .addra(addra[0:0]),
    .dina(dina), .enb(enb), .regceb(regceb), .addrb(addrb[0:0]),
    .doutb(doutb_l1), .sleep(sleep)
  );

  memory_sdpram #(
    .MEMORY_SIZE(96), .WRITE_DATA_WIDTH_A(32), .READ_DATA_WIDTH_B(32),
    .BYTE_WRITE_WIDTH_A(8), .ADDR_WIDTH_A(2), .ADDR_WIDTH_B(2),
    .READ_LATENCY_B(3), .READ_RESET_VALUE_B(32'h0)
  ) u_lat3 (
    .clka(clka), .rstb(rstb), .ena(ena), .wea(wea), .addra(addra),
    .dina(dina), .enb(enb), .regceb(regceb), .addrb(addrb),
    .doutb(doutb_l3), .sleep(sleep)
  );

  // Reference model state, index 0 = latency-1 RAM, index 1 = latency-3 RAM.
  logic [31:0] m_mem     [2][4];
  logic [31:0] m_cap     [2];
  bit          m_cap_ok  [2];
  logic [31:0] m_hist    [2][8];
  bit          m_hist_ok [2][8];
  logic [31:0] m_out     [2];
  bit          m_out_ok  [2];

  function automatic int lat_of(input int id);
    return (id == 0) ? 1 : 3;
  endfunction

  function automatic int depth_of(input int id);
    return (id == 0) ? 2 : 3;
  endfunction

  // Comparison helper: counts every comparison and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advances one model instance across the upcoming edge using the inputs
  // currently applied. All reads use pre-edge values (read-first).
  task automatic model_edge(input int id);
    int          ra;
    int          wa;
    int          n;
    logic [31:0] rv;
    logic [31:0] mask;
    bit          rd_fire;
    n  = lat_of(id);
    ra = (id == 0) ? int'(addrb[0]) : int'(addrb);
    wa = (id == 0) ? int'(addra[0]) : int'(addra);
    rv = (ra < depth_of(id)) ? m_mem[id][ra] : 32'h0;
    rd_fire = enb && !sleep;

    if (n == 1) begin
      if (rstb) begin
        m_out[id] = 32'h0; m_out_ok[id] = 1'b1;
      end else if (rd_fire) begin
        m_out[id] = rv; m_out_ok[id] = 1'b1;
      end
    end else begin
      // The output loads the capture made N-2 non-sleep edges before the last one.
      if (rstb) begin
        m_out[id] = 32'h0; m_out_ok[id] = 1'b1;
      end else if (regceb && !sleep) begin
        m_out[id]    = m_hist[id][n-2];
        m_out_ok[id] = m_hist_ok[id][n-2];
      end
    end

    if (rd_fire) begin
      m_cap[id] = rv; m_cap_ok[id] = 1'b1;
    end

    if (!sleep) begin
      for (int k = 7; k > 0; k--) begin
        m_hist[id][k]    = m_hist[id][k-1];
        m_hist_ok[id][k] = m_hist_ok[id][k-1];
      end
      m_hist[id][0]    = m_cap[id];
      m_hist_ok[id][0] = m_cap_ok[id];
    end

    if (ena && !sleep && wa < depth_of(id)) begin
      mask = {{8{wea[3]}}, {8{wea[2]}}, {8{wea[1]}}, {8{wea[0]}}};
      m_mem[id][wa] = (m_mem[id][wa] & ~mask) | (dina & mask);
    end
  endtask

  task automatic step(input string tag);
    model_edge(0);
    model_edge(1);
    @(posedge clka);
    #1;
    if (m_out_ok[0]) checkOutput({tag, "_lat1"}, doutb_l1, m_out[0]);
    if (m_out_ok[1]) checkOutput({tag, "_lat3"}, doutb_l3, m_out[1]);
  endtask

  task automatic applyStimulus(input string tag, input bit r, input bit ea,
                               input logic [3:0] w, input logic [1:0] aa,
                               input logic [31:0] d, input bit eb,
                               input bit rce, input logic [1:0] ab,
                               input bit slp);
    rstb = r; ena = ea; wea = w; addra = aa; dina = d;
    enb = eb; regceb = rce; addrb = ab; sleep = slp;
    step(tag);
  endtask

  initial begin
    for (int id = 0; id < 2; id++) begin
      for (int a = 0; a < 4; a++) m_mem[id][a] = 32'h0;
      for (int k = 0; k < 8; k++) begin
        m_hist[id][k] = 32'h0; m_hist_ok[id][k] = 1'b0;
      end
      m_cap[id] = 32'h0; m_cap_ok[id] = 1'b0;
      m_out[id] = 32'h0; m_out_ok[id] = 1'b0;
    end

    // Reset held while reading; ena=0 keeps wea from writing anything.
    for (int i = 0; i < 4; i++)
      applyStimulus("reset", 1, 0, 4'hF, 2'd0, 32'hFFFFFFFF, 1, 1, 2'd0, 0);
    applyStimulus("reset_sleep", 1, 0, 4'h0, 2'd0, 32'h0, 1, 1, 2'd0, 1);
    checkOutput("rst_value_lat1", doutb_l1, 32'h0);
    checkOutput("rst_value_lat3", doutb_l3, 32'h0);

    // Released: the array powers up as zeros.
    for (int i = 0; i < 3; i++)
      applyStimulus("init", 0, 0, 4'h0, 2'd0, 32'h0, 1, 1, 2'd0, 0);
    checkOutput("init_zero", doutb_l1, 32'h0);

    // Byte-lane writes.
    applyStimulus("wr_fe", 0, 1, 4'h1, 2'd0, 32'h000000FE, 1, 1, 2'd0, 0);
    applyStimulus("rd_fe", 0, 0, 4'h0, 2'd0, 32'h0, 1, 1, 2'd0, 0);
    checkOutput("lane0_fe", doutb_l1, 32'h000000FE);
    applyStimulus("wr_lane0", 0, 1, 4'h1, 2'd0, 32'h12345678, 1, 1, 2'd0, 0);
    applyStimulus("rd_lane0", 0, 0, 4'h0, 2'd0, 32'h0, 1, 1, 2'd0, 0);
    checkOutput("lane0_78", doutb_l1, 32'h00000078);
    applyStimulus("wr_full", 0, 1, 4'hF, 2'd0, 32'h12345678, 1, 1, 2'd0, 0);
    applyStimulus("rd_full", 0, 0, 4'h0, 2'd0, 32'h0, 1, 1, 2'd0, 0);
    checkOutput("full_word", doutb_l1, 32'h12345678);

    // Back-to-back writes with concurrent reads show the read-first lag.
    for (int i = 32'hFE; i <= 32'h105; i++) begin
      applyStimulus("sweep", 0, 1, 4'h1, 2'd0, 32'(i), 1, 1, 2'd0, 0);
      if (i != 32'hFE) checkOutput("sweep_lag", doutb_l1, 32'((i - 1) & 32'hFF) | 32'h12345600);
    end

    // ena=0 blocks the write regardless of wea.
    applyStimulus("ena_off", 0, 0, 4'hF, 2'd0, 32'hDEADBEEF, 1, 1, 2'd0, 0);
    applyStimulus("ena_off_rd", 0, 0, 4'h0, 2'd0, 32'h0, 1, 1, 2'd0, 0);
    checkOutput("ena_off_keep", doutb_l1, 32'h12345605);
    // sleep drops the write and freezes the output.
    applyStimulus("sleep_wr", 0, 1, 4'hF, 2'd0, 32'hCAFEF00D, 1, 1, 2'd1, 1);
    checkOutput("sleep_hold", doutb_l1, 32'h12345605);
    applyStimulus("sleep_rd", 0, 0, 4'h0, 2'd0, 32'h0, 1, 1, 2'd0, 0);
    checkOutput("sleep_dropped", doutb_l1, 32'h12345605);

    // Latency-3 pipeline.
    applyStimulus("l3_wr", 0, 1, 4'hF, 2'd1, 32'hA5A5A5A5, 0, 1, 2'd1, 0);
    applyStimulus("l3_rd", 0, 0, 4'h0, 2'd1, 32'h0, 1, 1, 2'd1, 0);
    applyStimulus("l3_wait", 0, 0, 4'h0, 2'd0, 32'h0, 0, 1, 2'd0, 0);
    applyStimulus("l3_wait", 0, 0, 4'h0, 2'd0, 32'h0, 0, 1, 2'd0, 0);
    checkOutput("l3_latency", doutb_l3, 32'hA5A5A5A5);
    // regceb=0 holds the output while the new word waits in the pipe.
    applyStimulus("l3_wr2", 0, 1, 4'hF, 2'd1, 32'h5A5A5A5A, 0, 0, 2'd1, 0);
    applyStimulus("l3_rd2", 0, 0, 4'h0, 2'd1, 32'h0, 1, 0, 2'd1, 0);
    for (int i = 0; i < 3; i++)
      applyStimulus("l3_regce0", 0, 0, 4'h0, 2'd0, 32'h0, 0, 0, 2'd0, 0);
    checkOutput("l3_regce_hold", doutb_l3, 32'hA5A5A5A5);
    applyStimulus("l3_regce1", 0, 0, 4'h0, 2'd0, 32'h0, 0, 1, 2'd0, 0);
    checkOutput("l3_regce_load", doutb_l3, 32'h5A5A5A5A);
    // Reset mid-pipeline; the in-flight word surfaces after release.
    applyStimulus("l3_wr3", 0, 1, 4'hF, 2'd1, 32'h3C3C3C3C, 0, 1, 2'd1, 0);
    applyStimulus("l3_rd3", 0, 0, 4'h0, 2'd1, 32'h0, 1, 1, 2'd1, 0);
    applyStimulus("l3_rst", 1, 0, 4'h0, 2'd0, 32'h0, 0, 1, 2'd0, 0);
    checkOutput("l3_rst_now", doutb_l3, 32'h0);
    applyStimulus("l3_rst_rel", 0, 0, 4'h0, 2'd0, 32'h0, 0, 1, 2'd0, 0);
    checkOutput("l3_after_rst", doutb_l3, 32'h3C3C3C3C);

    // Same-address collision: read-first, write still lands.
    applyStimulus("col_pre", 0, 1, 4'hF, 2'd1, 32'h22222222, 0, 1, 2'd1, 0);
    applyStimulus("col", 0, 1, 4'hF, 2'd1, 32'h11111111, 1, 1, 2'd1, 0);
    checkOutput("collision_old", doutb_l1, 32'h22222222);
    applyStimulus("col_after", 0, 0, 4'h0, 2'd1, 32'h0, 1, 1, 2'd1, 0);
    checkOutput("collision_new", doutb_l1, 32'h11111111);

    // Randomized traffic, including out-of-range address 3 on the 3-word RAM.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus("rand",
                    ($urandom_range(15) == 0),
                    1'($urandom_range(1)),
                    4'($urandom_range(15)),
                    2'($urandom_range(3)),
                    $urandom(),
                    ($urandom_range(3) != 0),
                    ($urandom_range(3) != 0),
                    2'($urandom_range(3)),
                    ($urandom_range(7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
